// File: rtl/kv_mem_arbiter_if.sv
// kv_mem_arbiter_if: requester and memory-side handshake bundle for kv_mem_arbiter
interface kv_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
);
    localparam int LINE_WIDTH = DATA_WIDTH * LINE_SIZE;
    logic                  i_i_req_valid;
    logic                  o_i_req_ready;
    logic [ADDR_WIDTH-1:0] i_i_req_addr;
    logic                  o_i_resp_valid;
    logic                  i_i_resp_ready;
    logic [LINE_WIDTH-1:0] o_i_resp_data;
    logic                  i_d_req_valid;
    logic                  o_d_req_ready;
    logic [ADDR_WIDTH-1:0] i_d_req_addr;
    logic                  i_d_req_we;
    logic [LINE_WIDTH-1:0] i_d_req_wdata;
    logic                  o_d_resp_valid;
    logic                  i_d_resp_ready;
    logic [LINE_WIDTH-1:0] o_d_resp_data;
    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_we;
    logic [LINE_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_rvalid;
    logic                  o_mem_rready;
    logic [LINE_WIDTH-1:0] i_mem_rdata;
    logic                  o_busy;
    modport slave (
        input  i_i_req_valid, i_i_req_addr, i_i_resp_ready,
        input  i_d_req_valid, i_d_req_addr, i_d_req_we, i_d_req_wdata, i_d_resp_ready,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_i_req_ready, o_i_resp_valid, o_i_resp_data,
        output o_d_req_ready, o_d_resp_valid, o_d_resp_data,
        output o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_rready, o_busy
    );
    modport master (
        output i_i_req_valid, i_i_req_addr, i_i_resp_ready,
        output i_d_req_valid, i_d_req_addr, i_d_req_we, i_d_req_wdata, i_d_resp_ready,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_i_req_ready, o_i_resp_valid, o_i_resp_data,
        input  o_d_req_ready, o_d_resp_valid, o_d_resp_data,
        input  o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_rready, o_busy
    );
endinterface

// File: rtl/kv_mem_arbiter.sv
// kv_mem_arbiter: round-robin sharing of one line-wide memory port between I and D refill
module kv_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    kv_mem_arbiter_if.slave bus
);
    localparam int LINEOFFSET_WIDTH = $clog2(LINE_SIZE);
    localparam int LINE_WIDTH = DATA_WIDTH * LINE_SIZE;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << LINEOFFSET_WIDTH) - ADDR_WIDTH'(1));
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t r_state, w_next;
    // owner and prio encode the requester: 0 = I, 1 = D
    logic r_owner, r_prio, r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata, r_i_rdata, r_d_rdata;
    logic w_grant_i, w_grant_d, w_done;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_i = !i_rst && bus.i_i_req_valid && (!bus.i_d_req_valid || !r_prio);
                w_grant_d = !i_rst && bus.i_d_req_valid && (!bus.i_i_req_valid || r_prio);
                w_next    = (w_grant_i || w_grant_d) ? REQ : IDLE;
            end
            REQ: begin
                w_done = bus.i_mem_ready && r_we;
                w_next = !bus.i_mem_ready ? REQ : r_we ? IDLE : WAIT;
            end
            WAIT: w_next = bus.i_mem_rvalid ? RESP : WAIT;
            RESP: begin
                w_done = r_owner ? bus.i_d_resp_ready : bus.i_i_resp_ready;
                w_next = w_done ? IDLE : RESP;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant_i || w_grant_d) begin
                r_owner <= w_grant_d;
                r_addr  <= (w_grant_d ? bus.i_d_req_addr : bus.i_i_req_addr) & ALIGN_MASK;
                r_we    <= w_grant_d && bus.i_d_req_we;
                r_wdata <= w_grant_d ? bus.i_d_req_wdata : '0;
            end
            if (r_state == WAIT && bus.i_mem_rvalid && !r_owner) r_i_rdata <= bus.i_mem_rdata;
            if (r_state == WAIT && bus.i_mem_rvalid && r_owner) r_d_rdata <= bus.i_mem_rdata;
            // the turn passes to the other requester only once a transaction fully retires
            if (w_done) r_prio <= !r_owner;
        end
    end

    assign bus.o_i_req_ready  = w_grant_i;
    assign bus.o_d_req_ready  = w_grant_d;
    assign bus.o_mem_valid    = r_state == REQ;
    assign bus.o_mem_addr     = r_addr;
    assign bus.o_mem_we       = r_we;
    assign bus.o_mem_wdata    = r_wdata;
    assign bus.o_mem_rready   = r_state == WAIT;
    assign bus.o_i_resp_valid = r_state == RESP && !r_owner;
    assign bus.o_d_resp_valid = r_state == RESP && r_owner;
    assign bus.o_i_resp_data  = r_i_rdata;
    assign bus.o_d_resp_data  = r_d_rdata;
    assign bus.o_busy         = r_state != IDLE;
endmodule

// File: doc/kv_mem_arbiter.md
Name: kv_mem_arbiter

Overview:
- Shares one line-wide memory port between two line-oriented requesters: instruction-cache refill (I) and data-cache refill/write-back (D).
- Round-robin arbitration with exactly one outstanding transaction.
- Sits between the cache fetch/write interfaces and the external memory model/bus.
- Reads return a full line to the owning requester. Writes are posted: complete on memory acceptance.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, address width (word-granular, as in the cache).
- LINE_SIZE, 4, words per line; LINEOFFSET_WIDTH = $clog2(LINE_SIZE).
- LINE_WIDTH (localparam), DATA_WIDTH*LINE_SIZE, line bus width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_i_req_valid  in  1  I read request valid.
- o_i_req_ready  out  1  I request accepted this cycle.
- i_i_req_addr  in  ADDR_WIDTH  I request address.
- o_i_resp_valid  out  1  I refill line valid.
- i_i_resp_ready  in  1  I consumes line.
- o_i_resp_data  out  LINE_WIDTH  I refill line.
- i_d_req_valid  in  1  D request valid.
- o_d_req_ready  out  1  D request accepted this cycle.
- i_d_req_addr  in  ADDR_WIDTH  D request address.
- i_d_req_we  in  1  1 = line write-back, 0 = refill read.
- i_d_req_wdata  in  LINE_WIDTH  write-back line.
- o_d_resp_valid  out  1  D refill line valid (reads only).
- i_d_resp_ready  in  1  D consumes line.
- o_d_resp_data  out  LINE_WIDTH  D refill line.
- o_mem_valid  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts request.
- o_mem_addr  out  ADDR_WIDTH  line-aligned address.
- o_mem_we  out  1  write strobe.
- o_mem_wdata  out  LINE_WIDTH  write line.
- i_mem_rvalid  in  1  read line returned.
- o_mem_rready  out  1  arbiter accepts read line.
- i_mem_rdata  in  LINE_WIDTH  read line.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; r_owner=I; r_prio=I (I wins the first tie); all valid/ready outputs 0; data/address outputs 0.
- All outputs are driven from registers or the state decode only. There are no combinational paths from i_mem_* to requester outputs.
- FSM states:
  - IDLE: o_*_req_ready=0.
    - If exactly one requester is valid, it is granted.
    - If both are valid, r_prio is granted.
    - On grant: latch addr (low LINEOFFSET_WIDTH bits forced to 0), we (I forces we=0), wdata, owner. Pulse that requester's o_*_req_ready for the grant cycle (combinational from valid and state=IDLE). Go to REQ.
  - REQ: o_mem_valid=1; addr/we/wdata are stable from latched registers.
    - On i_mem_ready with we=1: go to IDLE.
    - On i_mem_ready with we=0: go to WAIT.
    - Without i_mem_ready: hold; valid is never dropped.
  - WAIT: o_mem_rready=1. On i_mem_rvalid, latch i_mem_rdata into the owner's resp data register and go to RESP.
  - RESP: owner's o_*_resp_valid=1, data stable. On owner's resp_ready, go to IDLE.
- Priority update: r_prio flips to the non-owner on every transaction completion (write acceptance or resp handshake). It does not change while busy.
- Latency:
  - Grant to o_mem_valid: 1 cycle.
  - i_mem_rvalid to o_*_resp_valid: 1 cycle.
  - Minimum read turnaround with zero-wait memory: 4 cycles. Write turnaround: 2 cycles.
- Requests arriving while busy are not accepted (req_ready=0). The requester must hold valid/addr.
- i_mem_rvalid outside WAIT is ignored. It is a protocol error; no state change.
- Requester that drops valid before grant: no transaction is issued.
- Address wrap is not applicable: the address is passed through, aligned only.
- Reset asserted mid-transaction: immediate return to IDLE with all valids 0. The in-flight memory response is discarded.

Test Plan:
- I read 0x0000_0013 alone, memory ready same cycle, rdata=0xDDDD_CCCC_BBBB_AAAA..., rvalid 2 cycles later -> o_mem_addr=0x10, o_mem_we=0. o_i_resp_valid arrives 1 cycle after rvalid with matching line. o_d_resp_valid stays 0.
- I and D both valid from reset -> I granted first. After I completes, D is granted; then I again. Alternation holds over 6 back-to-back requests.
- D write-back addr 0x40, wdata=0x1111..., i_mem_ready delayed 3 cycles -> o_mem_valid/addr/wdata held stable 4 cycles. Return to IDLE on acceptance; no o_d_resp_valid.
- D read with i_d_resp_ready low for 5 cycles -> o_d_resp_valid and data held. o_i_req_ready stays 0 throughout though i_i_req_valid=1.
- Spurious i_mem_rvalid in IDLE and REQ -> no resp_valid, state unchanged.
- i_rst pulsed during WAIT -> next cycle all outputs 0, o_busy=0. Subsequent I request is served normally.
